// File: rtl/multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// multicycle_main_controller
//
// Moore-style main controller for the multi-cycle RISC-V datapath. Each
// instruction walks through fetch, decode, execute, memory and writeback
// states. Every state emits its own datapath strobes and mux selects.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   op         in   opcode code from the instruction register (OP_W bits)
//   func3      in   func3 field from the instruction register
//   zero, neg  in   ALU flags, used to resolve branches
//   mem_ready  in   memory access completes this cycle
//   pcWrite .. immSrc   out  datapath strobes and mux selects
//   instr_done out  one-cycle pulse on the last state of each instruction
//   illegal    out  sticky unknown-opcode flag (cleared only by reset)
//   state_dbg  out  current FSM state, for observation only
//
// Memory handshake: FETCH, MEM_READ and MEM_WRITE hold while mem_ready is low.
// mem_ready is sampled in the cycle it is presented. With MEM_HANDSHAKE = 0
// the input is ignored and every access completes in one cycle.
// -----------------------------------------------------------------------------
module multicycle_main_controller #(
  parameter int          OP_W          = 7,
  parameter int          R_T           = 0,
  parameter int          I_T           = 1,
  parameter int          S_T           = 2,
  parameter int          B_T           = 3,
  parameter int          U_T           = 4,
  parameter int          J_T           = 5,
  parameter logic [2:0]  F3_LW         = 3'b110,
  parameter logic [2:0]  F3_JALR       = 3'b111,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic [2:0]      func3,
  input  logic            zero,
  input  logic            neg,
  input  logic            mem_ready,
  output logic            pcWrite,
  output logic            pcSrc,
  output logic            adrSrc,
  output logic            memRead,
  output logic            memWrite,
  output logic            irWrite,
  output logic            regWrite,
  output logic [1:0]      resultSrc,
  output logic [1:0]      ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [2:0]      immSrc,
  output logic            instr_done,
  output logic            illegal,
  output logic [3:0]      state_dbg
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] EXEC_R    = 4'd2;
  localparam logic [3:0] EXEC_I    = 4'd3;
  localparam logic [3:0] ALU_WB    = 4'd4;
  localparam logic [3:0] MEM_ADDR  = 4'd5;
  localparam logic [3:0] MEM_READ  = 4'd6;
  localparam logic [3:0] MEM_WB    = 4'd7;
  localparam logic [3:0] MEM_WRITE = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] JALR_CALC = 4'd10;
  localparam logic [3:0] LINK      = 4'd11;
  localparam logic [3:0] LUI_WB    = 4'd12;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       mem_rdy;
  logic       is_r, is_i, is_s, is_b, is_u, is_j;
  logic       op_known;
  logic       br_taken;

  assign mem_rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_dbg = state;

  assign is_r     = (op == OP_W'(R_T));
  assign is_i     = (op == OP_W'(I_T));
  assign is_s     = (op == OP_W'(S_T));
  assign is_b     = (op == OP_W'(B_T));
  assign is_u     = (op == OP_W'(U_T));
  assign is_j     = (op == OP_W'(J_T));
  assign op_known = is_r | is_i | is_s | is_b | is_u | is_j;

  // Branch condition from the ALU flags of rs1 - rs2. Unsupported func3
  // encodings fall through as not-taken.
  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = neg;
      3'b101:  br_taken = ~neg;
      default: br_taken = 1'b0;
    endcase
  end

  // Immediate format follows the opcode in every state. The datapath can
  // then precompute the immediate as soon as the IR is loaded.
  always_comb begin
    immSrc = 3'b000;
    if      (is_i) immSrc = 3'b000;
    else if (is_s) immSrc = 3'b001;
    else if (is_b) immSrc = 3'b010;
    else if (is_j) immSrc = 3'b011;
    else if (is_u) immSrc = 3'b100;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE && !op_known)
        illegal <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    adrSrc     = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    regWrite   = 1'b0;
    resultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;

    case (state)
      FETCH: begin
        // The ALU computes PC+4 while the instruction is read. PC and IR
        // both load in the cycle the read completes.
        memRead = 1'b1;
        ALUSrcB = 2'b10;
        pcWrite = mem_rdy;
        irWrite = mem_rdy;
        if (mem_rdy) state_next = DECODE;
      end
      DECODE: begin
        // ALUOut <= oldPC + imm, which gives the branch/jal target early.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (is_r)      state_next = EXEC_R;
        else if (is_i) begin
          if (func3 == F3_LW)        state_next = MEM_ADDR;
          else if (func3 == F3_JALR) state_next = JALR_CALC;
          else                       state_next = EXEC_I;
        end
        else if (is_s) state_next = MEM_ADDR;
        else if (is_b) state_next = BRANCH;
        else if (is_u) state_next = LUI_WB;
        else if (is_j) state_next = LINK;
        else begin
          instr_done = 1'b1;
          state_next = FETCH;
        end
      end
      EXEC_R: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b10;
        state_next = ALU_WB;
      end
      EXEC_I: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUOp      = 2'b10;
        state_next = ALU_WB;
      end
      ALU_WB: begin
        resultSrc  = 2'b00;
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = is_i ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        adrSrc  = 1'b1;
        memRead = 1'b1;
        if (mem_rdy) state_next = MEM_WB;
      end
      MEM_WB: begin
        resultSrc  = 2'b01;
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      MEM_WRITE: begin
        adrSrc     = 1'b1;
        memWrite   = 1'b1;
        instr_done = mem_rdy;
        if (mem_rdy) state_next = FETCH;
      end
      BRANCH: begin
        // Target already sits in ALUOut from DECODE. The ALU compares rs1/rs2.
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b01;
        pcSrc      = 1'b1;
        pcWrite    = br_taken;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      JALR_CALC: begin
        // Overwrites the DECODE target with rs1 + imm.
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        state_next = LINK;
      end
      LINK: begin
        // rd <= oldPC + 4 straight from the ALU; PC <= ALUOut (the target).
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        resultSrc  = 2'b10;
        regWrite   = 1'b1;
        pcWrite    = 1'b1;
        pcSrc      = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      LUI_WB: begin
        resultSrc  = 2'b11;
        regWrite   = 1'b1;
        instr_done = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Reset squashes every architectural write, even mid-instruction.
    if (!rst) begin
      pcWrite    = 1'b0;
      irWrite    = 1'b0;
      regWrite   = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_controller
//
// Each instruction is expanded by a reference model into the list of
// per-cycle control words it should produce. That list comes from the
// instruction class, the memory wait counts and the branch rule. A monitor
// pops one expected word per cycle and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic       zero, neg, mem_ready;
  logic       pcWrite, pcSrc, adrSrc, memRead, memWrite, irWrite, regWrite;
  logic [1:0] resultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] immSrc;
  logic       instr_done, illegal;
  logic [3:0] state_dbg;

  typedef struct packed {
    logic       pc_wr, pc_src, adr_src, mem_rd, mem_wr, ir_wr, reg_wr;
    logic [1:0] res_src, src_a, src_b, alu_op;
    logic [2:0] imm;
    logic       done, ill;
  } ctl_t;

  logic [19:0] exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic        m_illegal  = 1'b0;

  multicycle_main_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .zero(zero), .neg(neg),
    .mem_ready(mem_ready), .pcWrite(pcWrite), .pcSrc(pcSrc), .adrSrc(adrSrc),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .regWrite(regWrite), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .immSrc(immSrc),
    .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [19:0] act, exp_w;
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      act = {pcWrite, pcSrc, adrSrc, memRead, memWrite, irWrite, regWrite,
             resultSrc, ALUSrcA, ALUSrcB, ALUOp, immSrc, instr_done, illegal};
      vectors++;
      if (act !== exp_w) begin
        miscompares++;
        $display("FAIL ctl_word t=%0t op=%0d f3=%b got=%b want=%b",
                 $time, op, func3, act, exp_w);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'd1:    return 3'b000;
      7'd2:    return 3'b001;
      7'd3:    return 3'b010;
      7'd5:    return 3'b011;
      7'd4:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f, input logic z, input logic n);
    case (f)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctl_t base();
    ctl_t c;
    c = '0;
    c.imm = imm_of(op);
    c.ill = m_illegal;
    return c;
  endfunction

  // One clock cycle: present inputs, queue the expected word, advance.
  task automatic step(input ctl_t c, input logic mr);
    mem_ready = mr;
    exp_q.push_back(c);
    @(posedge clk); #1;
  endtask

  task automatic alu_cycle(input logic [1:0] a, input logic [1:0] b, input logic [1:0] aop);
    ctl_t c;
    c = base(); c.src_a = a; c.src_b = b; c.alu_op = aop;
    step(c, 1'($urandom_range(0, 1)));
  endtask

  task automatic wb_cycle(input logic [1:0] rs);
    ctl_t c;
    c = base(); c.res_src = rs; c.reg_wr = 1'b1; c.done = 1'b1;
    step(c, 1'($urandom_range(0, 1)));
  endtask

  task automatic link_cycle();
    ctl_t c;
    c = base(); c.src_a = 2'b01; c.src_b = 2'b10; c.res_src = 2'b10;
    c.reg_wr = 1'b1; c.pc_wr = 1'b1; c.pc_src = 1'b1; c.done = 1'b1;
    step(c, 1'($urandom_range(0, 1)));
  endtask

  // Drive one whole instruction. fw/mw = cycles of mem_ready low in the
  // fetch and memory phases. abort: reset strikes during a stalled store.
  task automatic exec_instr(input logic [6:0] o, input logic [2:0] f,
                            input logic z, input logic n,
                            input int fw, input int mw, input bit abort);
    ctl_t c;
    op = o; func3 = f; zero = z; neg = n;
    // fetch
    c = base(); c.mem_rd = 1'b1; c.src_b = 2'b10;
    for (int i = 0; i < fw; i++) step(c, 1'b0);
    c.pc_wr = 1'b1; c.ir_wr = 1'b1;
    step(c, 1'b1);
    // decode
    c = base(); c.src_a = 2'b01; c.src_b = 2'b01;
    if (o > 7'd5) begin
      c.done = 1'b1;
      step(c, 1'($urandom_range(0, 1)));
      m_illegal = 1'b1;
      return;
    end
    step(c, 1'($urandom_range(0, 1)));
    case (o)
      7'd0: begin alu_cycle(2'b10, 2'b00, 2'b10); wb_cycle(2'b00); end
      7'd1: begin
        if (f == 3'b110) begin
          alu_cycle(2'b10, 2'b01, 2'b00);
          c = base(); c.adr_src = 1'b1; c.mem_rd = 1'b1;
          for (int i = 0; i < mw; i++) step(c, 1'b0);
          step(c, 1'b1);
          wb_cycle(2'b01);
        end else if (f == 3'b111) begin
          alu_cycle(2'b10, 2'b01, 2'b00);
          link_cycle();
        end else begin
          alu_cycle(2'b10, 2'b01, 2'b10);
          wb_cycle(2'b00);
        end
      end
      7'd2: begin
        alu_cycle(2'b10, 2'b01, 2'b00);
        c = base(); c.adr_src = 1'b1; c.mem_wr = 1'b1;
        if (abort) begin
          step(c, 1'b0);
          chk("store_memwrite_before_rst", 32'(memWrite), 32'd1);
          rst = 1'b0;
          #1;
          chk("memwrite_async_drop", 32'(memWrite), 32'd0);
          chk("strobes_in_rst",
              32'({pcWrite, irWrite, regWrite, memRead, memWrite, instr_done}), 32'd0);
          chk("illegal_cleared", 32'(illegal), 32'd0);
          m_illegal = 1'b0;
          @(posedge clk); #1;
          rst = 1'b1;
          return;
        end
        for (int i = 0; i < mw; i++) step(c, 1'b0);
        c.done = 1'b1;
        step(c, 1'b1);
      end
      7'd3: begin
        c = base(); c.src_a = 2'b10; c.alu_op = 2'b01; c.pc_src = 1'b1;
        c.done = 1'b1; c.pc_wr = taken(f, z, n);
        step(c, 1'($urandom_range(0, 1)));
      end
      7'd4: wb_cycle(2'b11);
      default: link_cycle();
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; op = '0; func3 = '0; zero = 1'b0; neg = 1'b0; mem_ready = 1'b1;
    #1;
    chk("reset_strobes",
        32'({pcWrite, irWrite, regWrite, memRead, memWrite, instr_done}), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // directed cases
    exec_instr(7'd0, 3'b000, 0, 0, 0, 0, 0);   // R-type, 4 cycles
    exec_instr(7'd1, 3'b110, 0, 0, 0, 3, 0);   // load, 3 stall cycles -> 8 cycles
    exec_instr(7'd3, 3'b000, 1, 0, 0, 0, 0);   // beq taken
    exec_instr(7'd3, 3'b000, 0, 0, 0, 0, 0);   // beq not taken
    exec_instr(7'd3, 3'b100, 0, 1, 0, 0, 0);   // blt taken
    exec_instr(7'd3, 3'b010, 1, 1, 0, 0, 0);   // unsupported func3
    exec_instr(7'd1, 3'b111, 0, 0, 0, 0, 0);   // jalr
    exec_instr(7'd5, 3'b000, 0, 0, 0, 0, 0);   // jal
    exec_instr(7'd2, 3'b010, 0, 0, 1, 2, 0);   // store with stalls
    exec_instr(7'd9, 3'b000, 0, 0, 0, 0, 0);   // illegal
    exec_instr(7'd4, 3'b000, 0, 0, 0, 0, 0);   // lui, illegal stays high
    exec_instr(7'd2, 3'b010, 0, 0, 0, 0, 1);   // reset mid-store
    exec_instr(7'd0, 3'b000, 0, 0, 0, 0, 0);   // runs cleanly after reset

    // randomized traffic
    for (int k = 0; k < 80; k++) begin
      logic [6:0] o;
      o = 7'($urandom_range(0, 6));
      if (o == 7'd6) o = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(6, 127)) : 7'd1;
      exec_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(0, 3), 0);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_main_controller.md
Name: multicycle_main_controller

Overview:
- Moore-FSM main controller for the multi-cycle RISC-V datapath. It replaces the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and emits per-state datapath strobes and mux selects.
- Stalls in memory states on a mem_ready handshake, resolves branches internally from ALU flags, and flags unknown opcodes.
- Sits between the instruction register (op/func3) and the shared-memory multi-cycle datapath.

Parameters:
OP_W, 7, opcode width
R_T, 0, R-type opcode code
I_T, 1, I-type opcode code (ALU-imm, load, jalr)
S_T, 2, store opcode code
B_T, 3, branch opcode code
U_T, 4, lui opcode code
J_T, 5, jal opcode code
F3_LW, 3'b110, func3 selecting load within I_T
F3_JALR, 3'b111, func3 selecting jalr within I_T
MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: mem_ready treated as constant 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op  in  OP_W  opcode from IR
func3  in  3  func3 from IR
zero  in  1  ALU result == 0
neg  in  1  ALU result negative
mem_ready  in  1  memory access completes this cycle
pcWrite  out  1  PC register load
pcSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut register
adrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  IR and oldPC load
regWrite  out  1  register file write
resultSrc  out  2  00 ALUOut, 01 mem data, 10 ALU result, 11 immediate
ALUSrcA  out  2  00 PC, 01 oldPC, 10 rs1
ALUSrcB  out  2  00 rs2, 01 imm, 10 const 4
ALUOp  out  2  00 add, 01 compare/sub, 10 decode func fields
immSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
instr_done  out  1  one-cycle pulse on the last state of each instruction
illegal  out  1  sticky unknown-opcode flag

Behaviour:
- Reset (rst = 0, async):
  - state <= FETCH; illegal <= 0.
  - While rst is low, pcWrite, irWrite, regWrite, memRead, memWrite and instr_done are forced to 0.
  - Reset mid-instruction aborts the instruction; no partial write survives.
- Outputs are decoded from state only, except the mem_ready-gated strobes and the branch pcWrite.
- Unlisted outputs are 0 in every state.
- immSrc is decoded from op in every state: I_T 000, S_T 001, B_T 010, J_T 011, U_T 100, other 000.
- FETCH: adrSrc=0, memRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, pcSrc=0.
  - irWrite = pcWrite = mem_ready.
  - mem_ready=0: stay in FETCH. mem_ready=1: go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut <= oldPC+imm). Next state:
  - R_T -> EXEC_R.
  - I_T: func3=F3_LW -> MEM_ADDR; func3=F3_JALR -> JALR_CALC; else EXEC_I.
  - S_T -> MEM_ADDR.
  - B_T -> BRANCH.
  - U_T -> LUI_WB.
  - J_T -> LINK.
  - Other op: illegal <= 1, instr_done=1, -> FETCH.
- EXEC_R: A=10, B=00, ALUOp=10 -> ALU_WB.
- EXEC_I: A=10, B=01, ALUOp=10 -> ALU_WB.
- ALU_WB: resultSrc=00, regWrite=1, instr_done=1 -> FETCH.
- MEM_ADDR: A=10, B=01, ALUOp=00. Next: load (op=I_T) -> MEM_READ; store -> MEM_WRITE.
- MEM_READ: adrSrc=1, memRead=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: resultSrc=01, regWrite=1, instr_done=1 -> FETCH.
- MEM_WRITE: adrSrc=1, memWrite=1 for every cycle in the state. Hold until mem_ready; instr_done = mem_ready; then -> FETCH.
- BRANCH: A=10, B=00, ALUOp=01, pcSrc=1, instr_done=1 -> FETCH.
  - pcWrite = taken:
    - func3 000 (beq): zero
    - func3 001 (bne): ~zero
    - func3 100 (blt): neg
    - func3 101 (bge): ~neg
    - any other func3: 0
- JALR_CALC: A=10, B=01, ALUOp=00 (ALUOut <= rs1+imm) -> LINK.
- LINK (jal and jalr):
  - A=01, B=10, ALUOp=00, resultSrc=10: rd <= oldPC+4.
  - regWrite=1, pcWrite=1, pcSrc=1, instr_done=1 -> FETCH.
- LUI_WB: resultSrc=11, regWrite=1, instr_done=1 -> FETCH.
- Latency with mem_ready tied high, in cycles:
  - R / I-ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - jalr: 4
  - lui: 3
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- illegal clears only on reset.

Test Plan:
- Reset asserted during MEM_WRITE with mem_ready=0 -> memWrite drops to 0 immediately (async); after release the FSM is in FETCH with illegal=0.
- R-type (op=0), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALU_WB; regWrite=1 only in cycle 4; instr_done pulses once.
- Load (op=1, func3=110), mem_ready low for 3 cycles in MEM_READ -> memRead held high 4 cycles, then MEM_WB with resultSrc=01, regWrite=1; total 8 cycles.
- Branches (op=3):
  - func3=000, zero=1 -> pcWrite=1, pcSrc=1 in BRANCH.
  - func3=000, zero=0 -> pcWrite=0.
  - func3=100, neg=1 -> pcWrite=1.
  - func3=010 -> pcWrite=0.
- jalr (op=1, func3=111) -> JALR_CALC then LINK with regWrite=1, pcWrite=1, pcSrc=1, resultSrc=10. jal (op=5) skips JALR_CALC.
- op=7'd9 -> illegal rises after DECODE and stays high through a following lui (op=4, resultSrc=11) until rst is pulsed low.
